// File: rtl/window3x3_stream.sv
`timescale 1ns/1ps
// window3x3_stream
//   Turns a raster pixel stream into one 3x3 neighbourhood per output
//   position. Two line buffers hold rows r-1 and r-2, and two column
//   registers hold the previous two columns of the current window row.
//
//   Build option WINDOW3X3_BORDER_REPLICATE_EN:
//     defined   - full-frame output with edge replication. A BUBBLE cycle
//                 after each row (from row 1 on) emits the right-edge window.
//                 A FLUSH of IMG_W+1 cycles emits the bottom row. in_ready
//                 drops during both.
//     undefined - interior-only output. in_ready is high except in reset.
//
//   Ports:
//     clk, rst             single clock, synchronous active-high reset
//     in_data/in_valid     pixel stream
//     in_sof               marks pixel (0,0)
//     in_ready             backpressure
//     out_valid            window taps and markers valid
//     out_sof/out_eol/out_eof  first window / row end / frame end
//     frame_err            one-cycle pulse when an early in_sof aborts a frame
//     matrix_p11..p33      window taps, row-major, p22 is the centre
module window3x3_stream #(
  parameter int DATA_W = 16,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_sof,
  output logic              in_ready,
  output logic              out_valid,
  output logic              out_sof,
  output logic              out_eol,
  output logic              out_eof,
  output logic              frame_err,
  output logic [DATA_W-1:0] matrix_p11,
  output logic [DATA_W-1:0] matrix_p12,
  output logic [DATA_W-1:0] matrix_p13,
  output logic [DATA_W-1:0] matrix_p21,
  output logic [DATA_W-1:0] matrix_p22,
  output logic [DATA_W-1:0] matrix_p23,
  output logic [DATA_W-1:0] matrix_p31,
  output logic [DATA_W-1:0] matrix_p32,
  output logic [DATA_W-1:0] matrix_p33
);

  // col must also reach IMG_W, which is the final FLUSH step.
  localparam int CW = $clog2(IMG_W + 1);
  localparam int AW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] COL_END  = CW'(IMG_W);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  typedef struct packed {
    logic [DATA_W-1:0] t;
    logic [DATA_W-1:0] m;
    logic [DATA_W-1:0] b;
  } column_t;

`ifdef WINDOW3X3_BORDER_REPLICATE_EN
  typedef enum logic [1:0] {IDLE, RUN, BUBBLE, FLUSH} state_t;
`else
  typedef enum logic [0:0] {IDLE, RUN} state_t;
`endif

  state_t            state, state_nx;
  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [DATA_W-1:0] lb1 [IMG_W];
  logic [DATA_W-1:0] lb2 [IMG_W];
  column_t           sr0, sr1;
  column_t           col_p0, left_p0, right_p0;
  logic [AW-1:0]     idx;
  logic              accept, start, sof_err, pix_run, row_end, frame_end;
  logic              shift, emit, mk_sof, mk_eol, mk_eof;
  column_t           win_l_p1, win_m_p1, win_r_p1;
  logic              vld_p1, sof_p1, eol_p1, eof_p1, err_p1;

`ifdef WINDOW3X3_BORDER_REPLICATE_EN
  assign in_ready = ~rst & ((state == IDLE) | (state == RUN));
`else
  assign in_ready = ~rst;
`endif

  always_comb begin
    accept    = in_valid & in_ready;
    // An accepted in_sof always restarts at (0,0); in RUN away from (0,0)
    // it also aborts the frame in progress.
    start     = accept & in_sof;
    sof_err   = start & (state == RUN) & ((row != '0) | (col != '0));
    pix_run   = accept & ~in_sof & (state == RUN);
    row_end   = (col == COL_LAST);
    frame_end = row_end & (row == ROW_LAST);
    if (start)
      idx = '0;
    else if (col < COL_END)
      idx = col[AW-1:0];
    else
      idx = '0;
  end

  // Stage p0: form the incoming column and select the window columns.
  always_comb begin
    col_p0.t = lb2[idx];
    col_p0.m = lb1[idx];
    col_p0.b = in_data;
    shift    = start | pix_run;
    emit     = 1'b0;
    mk_sof   = 1'b0;
    mk_eol   = 1'b0;
    mk_eof   = 1'b0;
    left_p0  = sr0;
    right_p0 = col_p0;
`ifdef WINDOW3X3_BORDER_REPLICATE_EN
    // Centre row 0 has no row above: reuse row 0 for the top tap.
    if (pix_run && row == RW'(1))
      col_p0.t = lb1[idx];
    case (state)
      RUN: begin
        if (pix_run && row != '0 && col != '0) begin
          emit = 1'b1;
          if (col == CW'(1))
            left_p0 = sr1;
          mk_sof = (row == RW'(1)) && (col == CW'(1));
        end
      end
      BUBBLE: begin
        emit     = 1'b1;
        right_p0 = sr1;
        mk_eol   = 1'b1;
      end
      FLUSH: begin
        // Bottom row replicated: the last stored row stands in for row IMG_H.
        col_p0.b = lb1[idx];
        if (col == COL_END) begin
          emit     = 1'b1;
          right_p0 = sr1;
          mk_eol   = 1'b1;
          mk_eof   = 1'b1;
        end else begin
          shift = 1'b1;
          if (col != '0) begin
            emit = 1'b1;
            if (col == CW'(1))
              left_p0 = sr1;
          end
        end
      end
      default: ;
    endcase
`else
    if (pix_run && row >= RW'(2) && col >= CW'(2)) begin
      emit   = 1'b1;
      mk_sof = (row == RW'(2)) && (col == CW'(2));
      mk_eol = row_end;
      mk_eof = frame_end;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (shift) begin
      sr0 <= sr1;
      sr1 <= col_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (start | pix_run) begin
      lb1[idx] <= in_data;
      lb2[idx] <= lb1[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (start)
          state_nx = RUN;
      end
      RUN: begin
        if (start)
          state_nx = RUN;
        else if (pix_run && row_end) begin
`ifdef WINDOW3X3_BORDER_REPLICATE_EN
          if (row != '0)
            state_nx = BUBBLE;
`else
          if (frame_end)
            state_nx = IDLE;
`endif
        end
      end
`ifdef WINDOW3X3_BORDER_REPLICATE_EN
      // row has already wrapped to 0 when the bubble follows the last row.
      BUBBLE: state_nx = (row == '0) ? FLUSH : RUN;
      FLUSH: begin
        if (col == COL_END)
          state_nx = IDLE;
      end
`endif
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (start) begin
      col <= CW'(1);
      row <= '0;
    end else if (pix_run) begin
      if (row_end) begin
        col <= '0;
        row <= frame_end ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
`ifdef WINDOW3X3_BORDER_REPLICATE_EN
    else if (state == FLUSH) begin
      col <= (col == COL_END) ? '0 : col + CW'(1);
    end
`endif
  end

  // Stage p1: registered window and markers.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      sof_p1   <= 1'b0;
      eol_p1   <= 1'b0;
      eof_p1   <= 1'b0;
      err_p1   <= 1'b0;
      win_l_p1 <= '0;
      win_m_p1 <= '0;
      win_r_p1 <= '0;
    end else begin
      vld_p1 <= emit;
      sof_p1 <= mk_sof;
      eol_p1 <= mk_eol;
      eof_p1 <= mk_eof;
      err_p1 <= sof_err;
      if (emit) begin
        win_l_p1 <= left_p0;
        win_m_p1 <= sr1;
        win_r_p1 <= right_p0;
      end
    end
  end

  assign out_valid  = vld_p1;
  assign out_sof    = sof_p1;
  assign out_eol    = eol_p1;
  assign out_eof    = eof_p1;
  assign frame_err  = err_p1;
  assign matrix_p11 = win_l_p1.t;
  assign matrix_p12 = win_m_p1.t;
  assign matrix_p13 = win_r_p1.t;
  assign matrix_p21 = win_l_p1.m;
  assign matrix_p22 = win_m_p1.m;
  assign matrix_p23 = win_r_p1.m;
  assign matrix_p31 = win_l_p1.b;
  assign matrix_p32 = win_m_p1.b;
  assign matrix_p33 = win_r_p1.b;

endmodule

// File: tb/tb_window3x3_stream.sv
`timescale 1ns/1ps
// Directed bench for window3x3_stream, IMG_W=4, IMG_H=3, pixel (r,c)=10r+c.
// Expectations follow the build option WINDOW3X3_BORDER_REPLICATE_EN.
module tb_window3x3_stream;
  localparam int DATA_W = 16;
  localparam int IMG_W  = 4;
  localparam int IMG_H  = 3;
`ifdef WINDOW3X3_BORDER_REPLICATE_EN
  localparam int R_LO = 0, R_HI = IMG_H - 1, C_LO = 0, C_HI = IMG_W - 1;
  localparam int EXP_LOW = 7;
  localparam int PRE_ERR = 1;
  localparam logic [143:0] FIRST_WIN = {16'd0, 16'd0, 16'd1, 16'd0, 16'd0, 16'd1, 16'd10, 16'd10, 16'd11};
  localparam logic [143:0] LAST_WIN  = {16'd12, 16'd13, 16'd13, 16'd22, 16'd23, 16'd23, 16'd22, 16'd23, 16'd23};
`else
  localparam int R_LO = 1, R_HI = IMG_H - 2, C_LO = 1, C_HI = IMG_W - 2;
  localparam int EXP_LOW = 0;
  localparam int PRE_ERR = 0;
  localparam logic [143:0] FIRST_WIN = {16'd0, 16'd1, 16'd2, 16'd10, 16'd11, 16'd12, 16'd20, 16'd21, 16'd22};
  localparam logic [143:0] LAST_WIN  = {16'd1, 16'd2, 16'd3, 16'd11, 16'd12, 16'd13, 16'd21, 16'd22, 16'd23};
`endif
  localparam int NWIN = (R_HI - R_LO + 1) * (C_HI - C_LO + 1);

  logic clk, rst;
  logic [DATA_W-1:0] in_data;
  logic in_valid, in_sof, in_ready;
  logic out_valid, out_sof, out_eol, out_eof, frame_err;
  logic [DATA_W-1:0] matrix_p11, matrix_p12, matrix_p13;
  logic [DATA_W-1:0] matrix_p21, matrix_p22, matrix_p23;
  logic [DATA_W-1:0] matrix_p31, matrix_p32, matrix_p33;
  logic [143:0] window;

  typedef struct packed {
    logic [143:0] taps;
    logic [2:0]   mk;
  } win_t;

  win_t wq[$];
  int   err_pulses = 0;
  int   ready_low  = 0;
  int   doubles    = 0;
  bit   prev_vld   = 1'b0;
  int   vectors    = 0;
  int   miscompares = 0;

  window3x3_stream #(.DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_sof(in_sof), .in_ready(in_ready),
    .out_valid(out_valid), .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof),
    .frame_err(frame_err),
    .matrix_p11(matrix_p11), .matrix_p12(matrix_p12), .matrix_p13(matrix_p13),
    .matrix_p21(matrix_p21), .matrix_p22(matrix_p22), .matrix_p23(matrix_p23),
    .matrix_p31(matrix_p31), .matrix_p32(matrix_p32), .matrix_p33(matrix_p33)
  );

  assign window = {matrix_p11, matrix_p12, matrix_p13, matrix_p21, matrix_p22,
                   matrix_p23, matrix_p31, matrix_p32, matrix_p33};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (out_valid) wq.push_back({window, out_sof, out_eol, out_eof});
    if (frame_err) err_pulses++;
    if (!rst && !in_ready) ready_low++;
    if (out_valid && prev_vld) doubles++;
    prev_vld = out_valid;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no end, expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [143:0] obs, input logic [143:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [143:0] model_win(input int r, input int c);
    logic [143:0] w;
    int rr, cc, k;
    w = '0;
    k = 0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        rr = r + dr;
        if (rr < 0) rr = 0;
        if (rr > IMG_H - 1) rr = IMG_H - 1;
        cc = c + dc;
        if (cc < 0) cc = 0;
        if (cc > IMG_W - 1) cc = IMG_W - 1;
        w[143 - 16*k -: 16] = 16'(10*rr + cc);
        k++;
      end
    end
    return w;
  endfunction

  task automatic push(input int r, input int c, input bit sof);
    int budget;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 16'(10*r + c);
    in_sof   = sof;
    budget   = 0;
    while (!in_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 50) check("push_ready", 144'(in_ready), 144'(1));
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    in_valid = 1'b0;
    in_sof   = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input bit gap);
    for (int i = 0; i < IMG_W*IMG_H; i++) begin
      push(i / IMG_W, i % IMG_W, i == 0);
      if (gap) begin
        @(negedge clk);
        in_valid = 1'b0;
        in_sof   = 1'b0;
      end
    end
  endtask

  task automatic check_frame(input int base, input string tag);
    int k;
    logic [2:0] mk;
    k = 0;
    check($sformatf("%s_count", tag), 144'(wq.size() - base), 144'(NWIN));
    for (int r = R_LO; r <= R_HI; r++) begin
      for (int c = C_LO; c <= C_HI; c++) begin
        mk = {k == 0, c == C_HI, (r == R_HI) && (c == C_HI)};
        if (base + k < wq.size()) begin
          check($sformatf("%s_taps_%0d_%0d", tag, r, c), 144'(wq[base+k].taps), model_win(r, c));
          check($sformatf("%s_marks_%0d_%0d", tag, r, c), 144'(wq[base+k].mk), 144'(mk));
        end
        k++;
      end
    end
  endtask

  initial begin
    int base, low0, err0, dbl0;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_sof = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready", 144'(in_ready), 144'(0));
    check("rst_out_valid", 144'(out_valid), 144'(0));
    check("rst_markers", 144'({out_sof, out_eol, out_eof, frame_err}), 144'(0));
    check("rst_window", window, 144'(0));
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 144'(in_ready), 144'(1));

    // Nominal frame, continuous input
    base = wq.size(); low0 = ready_low; err0 = err_pulses;
    send_frame(1'b0);
    idle(30);
    check_frame(base, "nom");
    if (wq.size() >= base + NWIN) begin
      check("nom_first_hand", wq[base].taps, FIRST_WIN);
      check("nom_last_hand", wq[base+NWIN-1].taps, LAST_WIN);
    end
    check("nom_ready_low_cycles", 144'(ready_low - low0), 144'(EXP_LOW));
    check("nom_no_frame_err", 144'(err_pulses - err0), 144'(0));

    // Early sof at stream index 6, starting a clean frame
    base = wq.size(); err0 = err_pulses;
    for (int i = 0; i < 6; i++) push(i / IMG_W, i % IMG_W, i == 0);
    send_frame(1'b0);
    idle(30);
    check("esof_frame_err_pulses", 144'(err_pulses - err0), 144'(1));
    check_frame(base + PRE_ERR, "esof");

    // Stall: in_valid 1-on/1-off
    base = wq.size(); dbl0 = doubles;
    send_frame(1'b1);
    idle(30);
    check_frame(base, "stall");
`ifndef WINDOW3X3_BORDER_REPLICATE_EN
    check("stall_no_back_to_back", 144'(doubles - dbl0), 144'(0));
`endif

    // Reset after pixel 5, then a fresh frame
    for (int i = 0; i < 6; i++) push(i / IMG_W, i % IMG_W, i == 0);
    @(negedge clk);
    in_valid = 1'b0;
    in_sof   = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    base = wq.size(); err0 = err_pulses;
    @(negedge clk);
    check("midrst_out_valid", 144'(out_valid), 144'(0));
    check("midrst_in_ready", 144'(in_ready), 144'(0));
    rst = 1'b0;
    idle(5);
    check("midrst_no_stale", 144'(wq.size() - base), 144'(0));
    send_frame(1'b0);
    idle(30);
    check_frame(base, "rstf");
    if (wq.size() > base) check("rstf_first_hand", wq[base].taps, FIRST_WIN);
    check("rstf_no_frame_err", 144'(err_pulses - err0), 144'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/window3x3_stream.md
# window3x3_stream

Parametrised 3x3 neighbourhood generator for the edge-detection pipeline, replacing the four fixed-width, fixed-size shift-RAM window stages with one reusable block. It accepts a raster pixel stream with frame and valid markers and holds two line buffers of depth `IMG_W`. It emits one 3x3 window per output position, with row, column and frame markers. A compile-time option selects either edge-replicated full-frame output or interior-only output, and the block drives the input backpressure that border handling requires.

## Interface
- `DATA_W`, 16, pixel / gradient word width. Covers 16-bit image and filter data and 26-bit gradient data.
- `IMG_W`, 640, pixels per line. Minimum 3.
- `IMG_H`, 512, lines per frame. Minimum 3.
- `clk` input 1: single clock. All logic on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_data` input DATA_W: pixel value.
- `in_valid` input 1: `in_data` is valid this cycle.
- `in_sof` input 1: qualifies pixel (0,0). Meaningful only when `in_valid` is high.
- `in_ready` output 1: block accepts the pixel this cycle. A transfer occurs when `in_valid & in_ready`.
- `out_valid` output 1: the window outputs are valid this cycle.
- `out_sof` output 1: first window of the frame.
- `out_eol` output 1: last window of the row.
- `out_eof` output 1: last window of the frame.
- `frame_err` output 1: one-cycle pulse when an early `in_sof` aborts a frame.
- `matrix_p11`..`matrix_p33` output DATA_W each: nine window taps, row-major, `p22` is the centre.

## Operation
- **Storage**
  - Two line buffers, each `IMG_W` x `DATA_W`, hold rows r-1 and r-2.
  - Three 3-tap column shift registers form the window.
- **Counters**
  - `col` runs 0..IMG_W-1 and `row` runs 0..IMG_H-1, both on accepted pixels.
  - `col` wraps to 0 with `row`+1.
- **FSM**
  - **IDLE**: `in_ready`=1. Pixels without `in_sof` are dropped. An accepted `in_sof` is pixel (0,0) and moves the FSM to RUN.
  - **RUN**: accepts pixels. After the last pixel of a row: if `row`>=1 and replicate mode, go to BUBBLE. After the last pixel of the frame: go to FLUSH in replicate mode, otherwise go to IDLE.
  - **BUBBLE** (replicate only): one cycle, `in_ready`=0, emits the right-edge window of row `row`-1, then returns to RUN.
  - **FLUSH** (replicate only): IMG_W+1 cycles, `in_ready`=0. Reads the line buffers to emit row IMG_H-1 with the bottom row replicated, then goes to IDLE.
- **Window for centre (r,c)**
  - Emitted when pixel (r+1,c+1) is accepted, or in the BUBBLE/FLUSH cycle that substitutes for it.
  - Out-of-frame taps take the nearest in-frame pixel: row clamp, then column clamp.
- **Emission set**
  - Interior mode: r in 1..IMG_H-2, c in 1..IMG_W-2, giving (IMG_W-2)(IMG_H-2) windows.
  - Replicate mode: all IMG_W*IMG_H windows.
- **Markers**
  - `out_sof` on the first window of the emission set.
  - `out_eol` on the last window of each emitted row.
  - `out_eof` on the last window of the frame, coincident with `out_eol`.
- **Early sof**: accepted `in_sof` while in RUN with (row,col) != (0,0):
  - Pulse `frame_err`.
  - Discard the partial frame; no further windows from it, no FLUSH.
  - Treat the pixel as (0,0) of a new frame.
- **Other rules**
  - `in_sof` at (0,0) in RUN is legal only immediately after a completed frame in interior mode.
  - `in_valid` low simply stalls; counters and window hold.
  - Arithmetic is pure data movement. No width change, no saturation.

## Timing
- Window outputs and markers are registered: valid 1 cycle after the accept (or BUBBLE/FLUSH cycle) that produces them.
- At most one window per cycle; `out_valid` never high two cycles per accept.
- Replicate throughput: IMG_W*IMG_H + (IMG_H-1) + IMG_W + 1 cycles per frame at full input rate.
- Interior mode: `in_ready` is tied high except in reset; the block never stalls.
- Reset values:
  - `in_ready`=0 during the `rst` cycle, 1 in the cycle after.
  - All other outputs, counters and FSM (IDLE) are 0.
  - Line-buffer contents are don't-care.
- Reset mid-frame aborts with no further output and no `frame_err`.

## Configuration
- `WINDOW3X3_BORDER_REPLICATE_EN`
  - Defined: BUBBLE and FLUSH states exist, edge replication is on, and full-frame output is produced, matching the input size for downstream stages.
  - Undefined: interior-only output, no backpressure, and the BUBBLE/FLUSH logic is not compiled.

## Test plan
All scenarios use IMG_W=4, IMG_H=3, DATA_W=16, pixel (r,c)=10r+c, continuous `in_valid`.
- **Interior mode, 12 pixels**
  - Exactly 2 windows.
  - First window: p11..p33 = 0,1,2,10,11,12,20,21,22, with `out_sof`.
  - Second window centred at 12, with `out_eol` and `out_eof`.
- **Replicate mode, full frame**
  - 12 windows.
  - Window (0,0) = 0,0,1,0,0,1,10,10,11.
  - Window (2,3) = 12,13,13,22,23,23,22,23,23, with `out_eof`.
  - `in_ready` low 1 cycle after pixels 7 and 11, then low 5 cycles of FLUSH.
- **Early sof**: `in_sof` at pixel index 6 → `frame_err` pulse 1 cycle. A clean 12-pixel frame that follows yields the nominal window count.
- **Stall**: `in_valid` toggled 1-on/1-off → windows identical to the back-to-back run, with `out_valid` gaps.
- **Reset**: `rst` asserted after pixel 5, then a fresh frame → no stale windows and correct first window.
